// File: rtl/kanagawa_callback_add_server.sv
// Add-callback responder: pops (a,b) from the request FIFO, sums them in a LATENCY-stage
// pipeline, and returns results through a credit-protected DEPTH-entry result buffer.
module kanagawa_callback_add_server #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_empty_in,
    input  logic [WIDTH-1:0] req_a_in,
    input  logic [WIDTH-1:0] req_b_in,
    output logic             req_rden_out,
    input  logic             res_rdy_in,
    output logic             res_valid_out,
    output logic [WIDTH-1:0] res_data_out,
    output logic [4:0]       inflight_out,
    output logic [31:0]      result_count_out
);
    localparam int         PW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [LATENCY:1]            vld_pipe_q, vld_pipe_d;
    logic [LATENCY:1][WIDTH-1:0] sum_pipe_q, sum_pipe_d;
    logic [WIDTH-1:0]            buf_mem_q [DEPTH];
    logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
    logic [4:0]                  buf_cnt_q, buf_cnt_d, pipe_occ;
    logic [31:0]                 result_count_q, result_count_d;
    logic                        armed_q;
    logic                        wr_en, rd_en;

    always_comb begin
        pipe_occ = '0;
        for (int i = 1; i <= LATENCY; i++) pipe_occ = pipe_occ + 5'(vld_pipe_q[i]);
        inflight_out  = pipe_occ + buf_cnt_q;
        // A pop reserves a buffer slot up front, so backpressure can never drop a result.
        req_rden_out  = armed_q && !req_empty_in && (inflight_out < DEPTH_C);
        res_valid_out = (buf_cnt_q != 5'd0);
        res_data_out  = res_valid_out ? buf_mem_q[head_q] : '0;
        wr_en         = vld_pipe_q[LATENCY];
        rd_en         = res_valid_out && res_rdy_in;

        vld_pipe_d    = '0;
        sum_pipe_d    = '0;
        vld_pipe_d[1] = req_rden_out;
        sum_pipe_d[1] = req_a_in + req_b_in;
        for (int i = 2; i <= LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            sum_pipe_d[i] = sum_pipe_q[i-1];
        end

        head_d         = rd_en ? head_q + PW'(1) : head_q;
        tail_d         = wr_en ? tail_q + PW'(1) : tail_q;
        buf_cnt_d      = buf_cnt_q + 5'(wr_en) - 5'(rd_en);
        result_count_d = result_count_q + 32'(rd_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q     <= '0;
            sum_pipe_q     <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            buf_cnt_q      <= '0;
            result_count_q <= '0;
            armed_q        <= 1'b0;
        end else begin
            vld_pipe_q     <= vld_pipe_d;
            sum_pipe_q     <= sum_pipe_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            buf_cnt_q      <= buf_cnt_d;
            result_count_q <= result_count_d;
            armed_q        <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        if (wr_en) buf_mem_q[tail_q] <= sum_pipe_q[LATENCY];
    end

    always_ff @(posedge clk) begin
        if (rst) assert (!(wr_en && buf_cnt_q == DEPTH_C));
    end

    assign result_count_out = result_count_q;
endmodule
